// File: rtl/stg_ma_pkg.sv
// Shared sizes, state encoding and counter width for the memory-access stage.
package stg_ma_pkg;

  localparam int unsigned SIZE_ADDR   = 12;
  localparam int unsigned SIZE_DATA   = 12;
  localparam int unsigned SIZE_OPC    = 6;
  localparam int unsigned SIZE_TGT_GP = 5;
  localparam int unsigned SIZE_TGT_SR = 4;

  localparam int unsigned HBIT_ADDR   = SIZE_ADDR - 1;
  localparam int unsigned HBIT_DATA   = SIZE_DATA - 1;
  localparam int unsigned HBIT_OPC    = SIZE_OPC - 1;
  localparam int unsigned HBIT_TGT_GP = SIZE_TGT_GP - 1;
  localparam int unsigned HBIT_TGT_SR = SIZE_TGT_SR - 1;

  // Width of the S_WAIT timeout counter.
  localparam int unsigned MA_CNT_W = 8;

  typedef enum logic {
    MA_S_IDLE = 1'b0,
    MA_S_WAIT = 1'b1
  } ma_state_e;

endpackage

// File: rtl/stg_ma_timeout.sv
// Saturating cycle counter for an outstanding memory transaction.
// o_tc is high during the TERMINAL-th enabled cycle after a clear.
module stg_ma_timeout
  import stg_ma_pkg::*;
#(
  parameter int unsigned TERMINAL = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [MA_CNT_W-1:0] TcVal = MA_CNT_W'(TERMINAL - 1);

  logic [MA_CNT_W-1:0] r_cnt;

  // Count enabled cycles; clear wins, hold at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of S_WAIT cycles already completed.
  assign o_tc = i_en && (r_cnt == TcVal);

endmodule

// File: rtl/stg_ma.sv
// Pipeline stage 5: memory access. Runs one load/store on the req/ack port,
// stalls the front pipe while it is outstanding and registers results for WB.
module stg_ma
  import stg_ma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst_n,
  input  logic                 iw_valid,
  input  logic                 iw_flush,
  input  logic [HBIT_ADDR:0]   iw_pc,
  input  logic [HBIT_DATA:0]   iw_instr,
  input  logic [HBIT_OPC:0]    iw_opc,
  input  logic                 iw_is_load,
  input  logic                 iw_is_store,
  input  logic [HBIT_ADDR:0]   iw_addr,
  input  logic [HBIT_DATA:0]   iw_store_data,
  input  logic [HBIT_DATA:0]   iw_result,
  input  logic [HBIT_ADDR:0]   iw_sr_result,
  input  logic [HBIT_TGT_GP:0] iw_tgt_gp,
  input  logic                 iw_tgt_gp_we,
  input  logic [HBIT_TGT_SR:0] iw_tgt_sr,
  input  logic                 iw_tgt_sr_we,
  output logic                 ow_stall,
  output logic                 ow_mem_req,
  output logic                 ow_mem_we,
  output logic [HBIT_ADDR:0]   ow_mem_addr,
  output logic [HBIT_DATA:0]   ow_mem_wdata,
  input  logic                 iw_mem_ack,
  input  logic [HBIT_DATA:0]   iw_mem_rdata,
  input  logic                 iw_mem_err,
  output logic [HBIT_ADDR:0]   ow_pc,
  output logic [HBIT_DATA:0]   ow_instr,
  output logic [HBIT_OPC:0]    ow_opc,
  output logic [HBIT_DATA:0]   ow_result,
  output logic [HBIT_ADDR:0]   ow_sr_result,
  output logic [HBIT_TGT_GP:0] ow_tgt_gp,
  output logic                 ow_tgt_gp_we,
  output logic [HBIT_TGT_SR:0] ow_tgt_sr,
  output logic                 ow_tgt_sr_we,
  output logic                 ow_fault
);

  ma_state_e r_state, w_state_nxt;

  logic w_in_wait, w_mem_op, w_start, w_tc, w_done, w_fault;
  logic r_killed;

  logic                 r_mem_req, r_mem_we;
  logic [HBIT_ADDR:0]   r_mem_addr;
  logic [HBIT_DATA:0]   r_mem_wdata;

  logic [HBIT_ADDR:0]   r_pc, r_sr_result;
  logic [HBIT_DATA:0]   r_instr, r_result;
  logic [HBIT_OPC:0]    r_opc;
  logic [HBIT_TGT_GP:0] r_tgt_gp;
  logic [HBIT_TGT_SR:0] r_tgt_sr;
  logic                 r_gp_we, r_sr_we, r_fault;

  logic [HBIT_DATA:0]   w_result_nxt;
  logic                 w_gp_we_nxt, w_sr_we_nxt;

  assign w_in_wait = (r_state == MA_S_WAIT);
  assign w_mem_op  = iw_is_load | iw_is_store;
  assign w_start   = (r_state == MA_S_IDLE) & iw_valid & w_mem_op & ~iw_flush;
  // Ack wins over timeout; an ack outside S_WAIT is ignored.
  assign w_done    = w_in_wait & (iw_mem_ack | w_tc);
  assign w_fault   = w_in_wait & (iw_mem_ack ? iw_mem_err : w_tc);
  assign ow_stall  = w_start | (w_in_wait & ~w_done);

  stg_ma_timeout #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (iw_clk),
    .i_rst_n (iw_rst_n),
    .i_clr   (w_start),
    .i_en    (w_in_wait),
    .o_tc    (w_tc)
  );

  // Next-state logic for the transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MA_S_IDLE: if (w_start) w_state_nxt = MA_S_WAIT;
      MA_S_WAIT: if (w_done)  w_state_nxt = MA_S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) r_state <= MA_S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Bus request registers; address/data/we are only loaded when starting, so stay stable.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= iw_is_store;
      r_mem_addr  <= iw_addr;
      r_mem_wdata <= iw_store_data;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Remember a flush seen while waiting, so the eventual completion writes nothing.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n)                  r_killed <= 1'b0;
    else if (w_start)               r_killed <= 1'b0;
    else if (w_in_wait && iw_flush) r_killed <= 1'b1;
  end

  // WB result and write enables: pass-through, bubble, or memory completion.
  always_comb begin
    w_result_nxt = iw_result;
    w_gp_we_nxt  = 1'b0;
    w_sr_we_nxt  = 1'b0;
    unique case (r_state)
      MA_S_IDLE: begin
        if (!w_start) begin
          w_gp_we_nxt = iw_tgt_gp_we & iw_valid & ~iw_flush;
          w_sr_we_nxt = iw_tgt_sr_we & iw_valid & ~iw_flush;
        end
      end
      MA_S_WAIT: begin
        if (w_done) begin
          w_result_nxt = iw_is_load ? iw_mem_rdata : iw_result;
          w_gp_we_nxt  = iw_tgt_gp_we & iw_valid & ~iw_flush & ~r_killed & ~w_fault;
          w_sr_we_nxt  = iw_tgt_sr_we & iw_valid & ~iw_flush & ~r_killed & ~w_fault;
        end
      end
    endcase
  end

  // WB pipeline register; payload is always latched, enables decide if WB acts.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_pc        <= '0;
      r_instr     <= '0;
      r_opc       <= '0;
      r_result    <= '0;
      r_sr_result <= '0;
      r_tgt_gp    <= '0;
      r_tgt_sr    <= '0;
      r_gp_we     <= 1'b0;
      r_sr_we     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pc        <= iw_pc;
      r_instr     <= iw_instr;
      r_opc       <= iw_opc;
      r_result    <= w_result_nxt;
      r_sr_result <= iw_sr_result;
      r_tgt_gp    <= iw_tgt_gp;
      r_tgt_sr    <= iw_tgt_sr;
      r_gp_we     <= w_gp_we_nxt;
      r_sr_we     <= w_sr_we_nxt;
      r_fault     <= w_fault;
    end
  end

  assign ow_mem_req   = r_mem_req;
  assign ow_mem_we    = r_mem_we;
  assign ow_mem_addr  = r_mem_addr;
  assign ow_mem_wdata = r_mem_wdata;
  assign ow_pc        = r_pc;
  assign ow_instr     = r_instr;
  assign ow_opc       = r_opc;
  assign ow_result    = r_result;
  assign ow_sr_result = r_sr_result;
  assign ow_tgt_gp    = r_tgt_gp;
  assign ow_tgt_gp_we = r_gp_we;
  assign ow_tgt_sr    = r_tgt_sr;
  assign ow_tgt_sr_we = r_sr_we;
  assign ow_fault     = r_fault;

endmodule
